// File: rtl/vmc_pkg.sv
// vmc_pkg: shared dispenser state encoding, coin denominations and coin value lookup
package vmc_pkg;
  typedef enum logic [2:0] {IDLE, SELECT, REQ, RELEASE, DONE, FAULT} state_t;
  localparam logic [7:0] COIN_10 = 8'd10;
  localparam logic [7:0] COIN_5 = 8'd5;
  localparam logic [7:0] COIN_1 = 8'd1;
  function automatic logic [7:0] coin_value(input logic [2:0] sel);
    return sel[2] ? COIN_10 : sel[1] ? COIN_5 : sel[0] ? COIN_1 : 8'd0;
  endfunction
endpackage

// File: rtl/change_coin_select.sv
// change_coin_select: greedy largest-available coin pick, one-hot {10,5,1}
module change_coin_select
  import vmc_pkg::*;
(
  input  logic [7:0] remain,
  input  logic       empty_10,
  input  logic       empty_5,
  input  logic       empty_1,
  output logic [2:0] coin_sel,
  output logic       no_coin
);
  logic t10, t5, t1;
  assign t10 = remain >= COIN_10 && !empty_10;
  assign t5 = remain >= COIN_5 && !empty_5;
  assign t1 = remain >= COIN_1 && !empty_1;
  assign coin_sel = t10 ? 3'b100 : t5 ? 3'b010 : t1 ? 3'b001 : 3'b000;
  assign no_coin = coin_sel == 3'b000;
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin change dispenser with 4-phase hopper handshake and ack timeout
module change_dispenser
  import vmc_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] change_in,
  input  logic       coin_ack,
  input  logic       empty_10,
  input  logic       empty_5,
  input  logic       empty_1,
  input  logic       clear,
  output logic       c10,
  output logic       c5,
  output logic       c1,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [7:0] remain
);
  localparam int TW = ACK_TIMEOUT > 255 ? $clog2(ACK_TIMEOUT + 1) : 8;
  state_t state, state_n;
  logic [7:0] remain_n;
  logic [TW-1:0] cnt, cnt_n;
  logic [2:0] coin, coin_n, sel;
  logic no_coin;
  assign coin = {c10, c5, c1};
  change_coin_select u_sel (
    .remain(remain),
    .empty_10(empty_10),
    .empty_5(empty_5),
    .empty_1(empty_1),
    .coin_sel(sel),
    .no_coin(no_coin)
  );
  always_comb begin
    state_n = state;
    remain_n = remain;
    cnt_n = cnt;
    coin_n = coin;
    case (state)
      IDLE: if (start) begin
        remain_n = change_in;
        state_n = SELECT;
      end
      SELECT: if (remain == 8'd0) state_n = DONE;
        else if (no_coin) state_n = FAULT;
        else if (!coin_ack) begin
          coin_n = sel;
          cnt_n = '0;
          state_n = REQ;
        end
      REQ: if (coin_ack) begin
        coin_n = 3'b000;
        remain_n = remain - coin_value(coin);
        state_n = RELEASE;
      end else if (cnt == TW'(ACK_TIMEOUT - 1)) begin
        coin_n = 3'b000;
        state_n = FAULT;
      end else cnt_n = cnt + 1'b1;
      RELEASE: state_n = coin_ack ? RELEASE : SELECT;
      DONE: state_n = IDLE;
      FAULT: state_n = clear ? IDLE : FAULT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      remain <= '0;
      cnt <= '0;
      {c10, c5, c1} <= 3'b000;
      busy <= 1'b0;
      done <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_n;
      remain <= remain_n;
      cnt <= cnt_n;
      {c10, c5, c1} <= coin_n;
      busy <= state_n == SELECT || state_n == REQ || state_n == RELEASE;
      done <= state_n == DONE;
      fault <= state_n == FAULT;
    end
  end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench driving a hopper model against change_dispenser
module tb_change_dispenser;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, coin_ack = 1'b0, clear = 1'b0;
  logic empty_10 = 1'b0, empty_5 = 1'b0, empty_1 = 1'b0;
  logic [7:0] change_in = 8'd0;
  logic c10, c5, c1, busy, done, fault;
  logic [7:0] remain;
  int tests = 0, fails = 0;
  logic [2:0] exp_q[$];
  always #5 clock = ~clock;
  change_dispenser dut (
    .clock(clock), .reset(reset), .start(start), .change_in(change_in),
    .coin_ack(coin_ack), .empty_10(empty_10), .empty_5(empty_5), .empty_1(empty_1),
    .clear(clear), .c10(c10), .c5(c5), .c1(c1), .busy(busy), .done(done),
    .fault(fault), .remain(remain)
  );
  function automatic int val(input logic [2:0] c);
    return c == 3'b100 ? 10 : c == 3'b010 ? 5 : c == 3'b001 ? 1 : 0;
  endfunction
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    tests++;
    if ({c10, c5, c1, busy, done, fault, remain} !== 14'd0) begin
      fails++;
      $display("FAIL reset: outputs=%b remain=%0d required all zero", {c10, c5, c1, busy, done, fault}, remain);
    end
    reset = 1'b0;
  endtask
  task automatic run(input string name, input logic [7:0] amt, input logic exp_fault, input logic [7:0] exp_rem);
    int rem;
    logic [2:0] got;
    logic finished;
    rem = amt;
    finished = 1'b0;
    change_in = amt;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || remain !== amt) begin
      fails++;
      $display("FAIL %s load: busy=%b remain=%0d required busy=1 remain=%0d", name, busy, remain, amt);
    end
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      got = {c10, c5, c1};
      if (got != 3'b000) begin
        tests++;
        if (exp_q.size() == 0 || got !== exp_q[0]) begin
          fails++;
          $display("FAIL %s coin: got=%b required=%b", name, got, exp_q.size() ? exp_q[0] : 3'b000);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        coin_ack = 1'b1;
        @(negedge clock);
        rem -= val(got);
        tests++;
        if ({c10, c5, c1} !== 3'b000 || remain !== 8'(rem)) begin
          fails++;
          $display("FAIL %s ack: coins=%b remain=%0d required coins=000 remain=%0d", name, {c10, c5, c1}, remain, rem);
        end
        coin_ack = 1'b0;
        @(negedge clock);
      end else if (done || fault) finished = 1'b1;
      else @(negedge clock);
    end
    tests++;
    if (!finished || fault !== exp_fault || remain !== exp_rem || exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s end: finished=%b fault=%b remain=%0d left=%0d required fault=%b remain=%0d left=0",
               name, finished, fault, remain, exp_q.size(), exp_fault, exp_rem);
    end
    if (!exp_fault) begin
      @(negedge clock);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL %s done_pulse: done=%b busy=%b required 0 0", name, done, busy);
      end
    end
  endtask
  task automatic test_greedy_27;
    exp_q = '{3'b100, 3'b100, 3'b010, 3'b001, 3'b001};
    run("greedy27", 8'd27, 1'b0, 8'd0);
  endtask
  task automatic test_zero;
    logic [4:0] exp [3];
    exp = '{5'b10000, 5'b01000, 5'b00000};
    change_in = 8'd0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({busy, done, c10, c5, c1} !== exp[i]) begin
        fails++;
        $display("FAIL zero cycle%0d: busy,done,coins=%b required=%b", i + 1, {busy, done, c10, c5, c1}, exp[i]);
      end
      @(negedge clock);
    end
  endtask
  task automatic test_empty10_23;
    empty_10 = 1'b1;
    exp_q = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b001, 3'b001};
    run("empty10_23", 8'd23, 1'b0, 8'd0);
    empty_10 = 1'b0;
  endtask
  task automatic test_empty1_fault;
    empty_1 = 1'b1;
    exp_q = '{3'b010};
    run("empty1_7", 8'd7, 1'b1, 8'd2);
    start = 1'b1;
    change_in = 8'd50;
    repeat (3) @(negedge clock);
    start = 1'b0;
    tests++;
    if (fault !== 1'b1 || remain !== 8'd2 || busy !== 1'b0) begin
      fails++;
      $display("FAIL fault_hold: fault=%b remain=%0d busy=%b required 1 2 0", fault, remain, busy);
    end
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    tests++;
    if (fault !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL fault_clear: fault=%b busy=%b required 0 0", fault, busy);
    end
    empty_1 = 1'b0;
  endtask
  task automatic test_timeout;
    int n;
    n = 0;
    change_in = 8'd10;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    while (c10 && n < 400) begin
      n++;
      @(negedge clock);
    end
    tests++;
    if (n != 255 || fault !== 1'b1 || c10 !== 1'b0 || remain !== 8'd10) begin
      fails++;
      $display("FAIL timeout: high=%0d fault=%b c10=%b remain=%0d required 255 1 0 10", n, fault, c10, remain);
    end
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask
  task automatic test_reset_mid;
    int seen, guard;
    seen = 0;
    guard = 0;
    change_in = 8'd15;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    while (seen < 2 && guard < 50) begin
      guard++;
      if (c10) begin
        seen++;
        coin_ack = 1'b1;
        @(negedge clock);
        coin_ack = 1'b0;
        @(negedge clock);
      end else if (c5) seen++;
      else @(negedge clock);
    end
    tests++;
    if (c5 !== 1'b1 || seen != 2) begin
      fails++;
      $display("FAIL reset_mid reach: c5=%b seen=%0d required 1 2", c5, seen);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    tests++;
    if ({c10, c5, c1, busy, done, fault, remain} !== 14'd0) begin
      fails++;
      $display("FAIL reset_mid: outputs=%b remain=%0d required all zero", {c10, c5, c1, busy, done, fault}, remain);
    end
    exp_q = '{3'b010, 3'b001};
    run("after_reset", 8'd6, 1'b0, 8'd0);
  endtask
  task automatic test_back_to_back;
    exp_q = '{3'b001, 3'b001};
    run("b2b_a", 8'd2, 1'b0, 8'd0);
    exp_q = '{3'b100, 3'b100, 3'b100, 3'b010};
    run("b2b_b", 8'd35, 1'b0, 8'd0);
  endtask
  initial begin
    test_reset;
    test_greedy_27;
    test_zero;
    test_empty10_23;
    test_empty1_fault;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
